// File: rtl/mmio_store_fifo.sv
// Memory-mapped store FIFO: core stores to DATA are queued and drained to an
// external consumer over valid/ready; STATUS and SENT are readable for polling.
module mmio_store_fifo #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] MMIO_BASE = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic        is_mmio,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  // Handshake: a word leaves the FIFO on any rising edge where out_valid and
  // out_ready are both high; out_valid/out_data depend only on stored state.

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   sent_q, sent_d;

  logic sel_data, sel_status, sel_sent, sel_ctrl;
  logic full, empty, deq, enq, data_store, flush;

  // Registers live in the first 16 bytes of the region; everything else is a hole.
  assign is_mmio    = (addr[31:16] == MMIO_BASE);
  assign sel_data   = is_mmio && (addr[15:0] == 16'h0000);
  assign sel_status = is_mmio && (addr[15:0] == 16'h0004);
  assign sel_sent   = is_mmio && (addr[15:0] == 16'h0008);
  assign sel_ctrl   = is_mmio && (addr[15:0] == 16'h000C);

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign out_valid  = !empty;
  assign out_data   = mem_q[rd_ptr_q];

  assign deq        = out_valid && out_ready;
  assign data_store = sel_data && mem_write;
  assign enq        = data_store && (!full || deq);
  assign stall      = data_store && full && !deq;
  assign flush      = sel_ctrl && mem_write && wdata[0];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    sent_d   = sent_q;
    if (deq) begin
      sent_d = sent_q + 32'd1;
    end
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d = count_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
    end
  end

  // Storage has no reset; contents are only visible through count-qualified reads.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= wdata;
  end

  always_comb begin
    rdata = '0;
    if (mem_read) begin
      if (sel_data)   rdata = out_valid ? out_data : 32'd0;
      if (sel_status) rdata = {16'h0000, 8'(count_q), 6'b000000, full, empty};
      if (sel_sent)   rdata = sent_q;
    end
  end

endmodule

// File: tb/tb_mmio_store_fifo.sv
// Directed bench for mmio_store_fifo: a queue model predicts every dequeued
// word, stall, out_valid and register read.
module tb_mmio_store_fifo;

  localparam int DEPTH = 4;
  localparam logic [31:0] A_DATA   = 32'hFFFF0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF0004;
  localparam logic [31:0] A_SENT   = 32'hFFFF0008;
  localparam logic [31:0] A_CTRL   = 32'hFFFF000C;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic        mem_write, mem_read;
  logic        is_mmio, stall, out_valid, out_ready;
  logic [31:0] rdata, out_data;

  logic [31:0] exp_q[$];
  int unsigned m_sent;
  int          n_cmp = 0;
  int          n_err = 0;

  mmio_store_fifo #(.DEPTH(DEPTH), .MMIO_BASE(16'hFFFF)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata),
    .mem_write(mem_write), .mem_read(mem_read), .is_mmio(is_mmio),
    .rdata(rdata), .stall(stall), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    addr = a; wdata = d; mem_write = w; mem_read = r;
  endtask

  // Checks the cycle's combinational outputs against the model, advances the
  // model by one edge, then waits to the next falling edge.
  task automatic step(output bit stalled);
    bit data_st, ctrl_flush, exp_deq, exp_stall;
    #1;
    data_st    = mem_write && (addr == A_DATA);
    ctrl_flush = mem_write && (addr == A_CTRL) && wdata[0];
    exp_deq    = (exp_q.size() != 0) && out_ready;
    exp_stall  = data_st && (exp_q.size() == DEPTH) && !exp_deq;
    check("stall", 32'(stall), 32'(exp_stall));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (reset) begin
      exp_q.delete();
      m_sent = 0;
    end else begin
      if (exp_deq) begin
        check("out_data", out_data, exp_q[0]);
        void'(exp_q.pop_front());
        m_sent++;
      end
      if (data_st && !exp_stall) exp_q.push_back(wdata);
      if (ctrl_flush) exp_q.delete();
    end
    stalled = exp_stall;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_step();
    bit s;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    step(s);
  endtask

  // Store retried until accepted, like the core holding PC on stall.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit rand_ready);
    bit s;
    int tries;
    drive(a, d, 1'b1, 1'b0);
    tries = 0;
    step(s);
    while (s && tries < 64) begin
      tries++;
      if (rand_ready) out_ready = (tries > 8) ? 1'b1 : 1'($urandom_range(0, 1));
      step(s);
    end
    if (s) check("store_timeout", 32'(s), 32'd0);
    drive(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp, input string tag);
    drive(a, 32'h0, 1'b0, 1'b1);
    #1;
    check(tag, rdata, exp);
    drive(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    bit s;
    int guard;
    reset = 1'b1;
    out_ready = 1'b0;
    m_sent = 0;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    step(s);
    reset = 1'b0;

    // Reset state
    load(A_STATUS, 32'h0000_0001, "status_reset");
    load(A_SENT, 32'h0, "sent_reset");
    load(A_DATA, 32'h0, "data_empty_reset");
    idle_step();

    // Fill, then stall on the fifth store
    store(A_DATA, 32'hA, 1'b0);
    store(A_DATA, 32'hB, 1'b0);
    store(A_DATA, 32'hC, 1'b0);
    store(A_DATA, 32'hD, 1'b0);
    load(A_STATUS, 32'h0000_0402, "status_full");
    load(A_DATA, 32'hA, "data_peek");
    drive(A_DATA, 32'hE, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(s);
      check("stall_hold", 32'(s), 32'd1);
    end
    out_ready = 1'b1;
    step(s);
    check("stall_release", 32'(s), 32'd0);
    drive(A_STATUS, 32'h0, 1'b0, 1'b1);
    #1;
    check("status_full_after_swap", rdata, 32'h0000_0402);
    for (int i = 0; i < 4; i++) idle_step();
    idle_step();
    load(A_SENT, 32'd5, "sent_5");
    load(A_STATUS, 32'h0000_0001, "status_drained");

    // Ten words with intermittent ready, forcing pointer wrap
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      store(A_DATA, 32'h100 + i, 1'b1);
    end
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      idle_step();
      guard++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    idle_step();
    load(A_SENT, m_sent, "sent_after_wrap");
    load(A_STATUS, 32'h0000_0001, "status_after_wrap");

    // Flush, holes and out-of-region addresses
    out_ready = 1'b0;
    store(A_DATA, 32'h200, 1'b0);
    store(A_DATA, 32'h201, 1'b0);
    store(A_DATA, 32'h202, 1'b0);
    load(A_STATUS, 32'h0000_0300, "status_three");
    load(A_DATA, 32'h200, "data_head");
    load(A_CTRL, 32'h0, "ctrl_read");
    store(A_STATUS, 32'h0, 1'b0);
    load(A_STATUS, 32'h0000_0300, "status_ro");
    store(A_CTRL, 32'h1, 1'b0);
    idle_step();
    load(A_STATUS, 32'h0000_0001, "status_flushed");
    store(32'hFFFF0010, 32'h55, 1'b0);
    load(A_STATUS, 32'h0000_0001, "status_hole_store");
    load(32'hFFFF0014, 32'h0, "hole_read_14");
    load(32'hFFFF0010, 32'h0, "hole_read_10");
    load(A_DATA, 32'h0, "data_empty_flushed");
    load(32'h00001000, 32'h0, "non_mmio_read");
    check("is_mmio_low", 32'(is_mmio), 32'd0);
    drive(A_SENT, 32'h0, 1'b0, 1'b0);
    #1;
    check("rdata_no_read", rdata, 32'h0);
    check("is_mmio_high", 32'(is_mmio), 32'd1);
    idle_step();

    // Reset while full with a stall pending
    for (int i = 0; i < DEPTH; i++) store(A_DATA, 32'h300 + i, 1'b0);
    drive(A_DATA, 32'h77, 1'b1, 1'b0);
    #1;
    check("stall_before_reset", 32'(stall), 32'd1);
    reset = 1'b1;
    step(s);
    #1;
    check("stall_in_reset", 32'(stall), 32'd0);
    check("out_valid_in_reset", 32'(out_valid), 32'd0);
    load(A_STATUS, 32'h0000_0001, "status_in_reset");
    load(A_SENT, 32'h0, "sent_in_reset");
    reset = 1'b0;
    idle_step();
    store(A_DATA, 32'h400, 1'b0);
    out_ready = 1'b1;
    idle_step();
    idle_step();
    load(A_SENT, 32'd1, "sent_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
